load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-access stage between the datapath and data memory, directly upstream of the load byte/halfword sign extender. It latches one load or store request and drives a word-aligned memory transaction with byte enables. It waits on a memory acknowledge with a timeout. For loads, it returns the addressed byte, halfword or word right-aligned, together with the 2-bit size select the extender consumes.

## Interface
- `TIMEOUT`, default 15: maximum cycles `mem_req` stays high without `mem_ack` before the access is aborted.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: request strobe; sampled only in IDLE.
- `we` in 1: 1 = store, 0 = load.
- `size` in 2: access size.
  - 00 = word; 01 = byte; 10 = halfword.
  - 11 is reserved and treated as word.
  - The encoding matches the extender's select: bit0 = byte, bit1 = half.
- `addr` in 32: byte address.
- `wdata` in 32: store data, right-aligned.
- `busy` out 1: high in every state except IDLE.
- `mem_req` out 1: memory request, held until ack or timeout.
- `mem_we` out 1: write enable to memory.
- `mem_addr` out 32: `{addr[31:2], 2'b00}`.
- `mem_be` out 4: byte-lane enables.
- `mem_wdata` out 32: store data replicated onto the enabled lanes.
- `mem_rdata` in 32: read data, valid in the `mem_ack` cycle.
- `mem_ack` in 1: memory acknowledge.
- `ld_data` out 32: loaded data, right-aligned, with unused upper bits zero; holds until the next load completes.
- `ld_sel` out 2: the latched `size` of the last completed load, for the extender.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: valid with `done`; high on timeout or a misaligned trap.

## Operation
- Memory is little-endian. Lane k is bits [8k+7:8k], selected by `addr[1:0]`.
- Byte enables:
  - Byte: `mem_be` = 1 << `addr[1:0]`.
  - Half: `mem_be` = 0011 if `addr[1]` = 0, else 1100.
  - Word: `mem_be` = 1111.
- Store data: byte replicated ×4, half replicated ×2, word unchanged.
- Load alignment: `ld_data` = `mem_rdata` >> (8 × offset), masked to 8, 16 or 32 bits. Offset is `addr[1:0]` for byte, `{addr[1], 0}` for half, and 0 for word.
- States: IDLE, ISSUE, DONE.
- IDLE:
  - `start` = 1 latches `we`, `size`, `addr` and `wdata`.
  - The next state is ISSUE, or DONE with `err` = 1 if a misaligned trap fires (see Configuration).
- ISSUE:
  - `mem_req` = 1 and the wait counter increments each cycle.
  - `mem_ack` = 1 leads to DONE. On a load, `ld_data` and `ld_sel` are captured in that same edge.
  - Counter = `TIMEOUT` − 1 with no ack leads to DONE with `err` = 1; `ld_data` is unchanged.
  - If `mem_ack` arrives on the timeout cycle, the ack wins and `err` = 0.
- DONE: `done` = 1 for one cycle, then the next state is IDLE. The wait counter clears.
- `start` outside IDLE is ignored; there is no queueing.
- `mem_ack` outside ISSUE is ignored.
- Reset, including mid-access:
  - State returns to IDLE and the counter to 0.
  - `busy`, `mem_req`, `mem_we`, `done` and `err` go to 0.
  - `mem_addr`, `mem_be`, `mem_wdata` and `ld_data` go to 0; `ld_sel` goes to 00.
  - The aborted access produces no `done`.

## Timing
- All outputs are registered.
- `start` sampled at edge T gives `busy` = 1 and `mem_req` = 1 from T+1.
- `mem_ack` at edge T+1+k gives `done`, `ld_data` and `ld_sel` valid from T+2+k.
- Minimum latency is start → done in 2 cycles (ack in the first ISSUE cycle).
- `mem_addr`, `mem_be`, `mem_we` and `mem_wdata` are stable for the whole of ISSUE.
- `mem_req` deasserts in the cycle after the ack, or after the timeout.
- Back-to-back throughput: a new `start` is accepted in the cycle after `done`.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A half with `addr[0]` = 1, or a word with `addr[1:0]` ≠ 0, goes IDLE → DONE with `err` = 1.
  - No `mem_req` is issued and `ld_data` is unchanged.
  - Latency is 2 cycles.
- Not defined: misaligned low address bits are ignored. A half uses `addr[1]` only, a word uses lanes 1111, and `err` comes from timeout only.

## Test plan
- Byte load, `addr` = 0x103, `mem_rdata` = 0xA1B2C3D4, ack after 0 waits:
  - `mem_addr` = 0x100, `mem_be` = 1000.
  - `ld_data` = 0x000000A1, `ld_sel` = 01.
  - `done` arrives 2 cycles after `start`.
- Half store, `addr` = 0x202, `wdata` = 0x0000BEEF, ack after 3 waits:
  - `mem_be` = 1100, `mem_wdata` = 0xBEEFBEEF, `mem_we` = 1.
  - `done` arrives 5 cycles after `start`, `err` = 0.
- Word load with no ack, `TIMEOUT` = 15:
  - `mem_req` is high for 15 cycles.
  - `done` = 1 and `err` = 1; `ld_data` is unchanged.
- Half load, `addr` = 0x301:
  - With the macro: `done` and `err` = 1 with no `mem_req`.
  - Without the macro: `mem_be` = 0011 and `ld_data` = `mem_rdata`[15:0].
- `start` pulsed in ISSUE, then `rst_n` low for 1 cycle mid-ISSUE:
  - The second `start` is ignored.
  - After reset, all outputs are 0, `done` never pulses, and a fresh word load completes normally.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Request, memory and load-return signals of the load/store unit.
// master = datapath/memory side, slave = load_store_unit.
interface load_store_unit_if;
  logic        start;
  logic        we;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] ld_data;
  logic [1:0]  ld_sel;
  logic        done;
  logic        err;

  modport master (
    output start, we, size, addr, wdata, mem_rdata, mem_ack,
    input  busy, mem_req, mem_we, mem_addr, mem_be, mem_wdata, ld_data, ld_sel, done, err
  );

  modport slave (
    input  start, we, size, addr, wdata, mem_rdata, mem_ack,
    output busy, mem_req, mem_we, mem_addr, mem_be, mem_wdata, ld_data, ld_sel, done, err
  );
endinterface

// File: rtl/load_store_unit.sv
// Single-request load/store unit: word-aligned memory access with byte enables and ack timeout.
// Optional LSU_MISALIGN_TRAP_EN: misaligned half/word requests complete with err and no memory access.
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | mem_req high, waiting for mem_ack or timeout
// DONE  | done pulse (a trapped request spends one extra quiet cycle here first)
module load_store_unit #(
  parameter int TIMEOUT = 15
) (
  input logic             clk,
  input logic             rst_n,
  load_store_unit_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [1:0]    req_size;
  logic [1:0]    req_off;
  logic          req_we;
  logic          trap_pend;

  logic [3:0]    be_next;
  logic [31:0]   wdata_next;
  logic [1:0]    off_next;
  logic          trap;
  logic [31:0]   rshift;
  logic [31:0]   ld_next;

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = bus.wdata;
    off_next   = 2'b00;
    trap       = 1'b0;
    case (bus.size)
      2'b01: begin
        be_next    = 4'b0001 << bus.addr[1:0];
        wdata_next = {4{bus.wdata[7:0]}};
        off_next   = bus.addr[1:0];
      end
      2'b10: begin
        be_next    = bus.addr[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{bus.wdata[15:0]}};
        off_next   = {bus.addr[1], 1'b0};
      end
      default: ;
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    trap = ((bus.size == 2'b10) && bus.addr[0]) ||
           ((bus.size[0] == bus.size[1]) && (bus.addr[1:0] != 2'b00));
`else
    trap = 1'b0;
`endif
  end

  always_comb begin
    rshift = bus.mem_rdata >> {req_off, 3'b000};
    case (req_size)
      2'b01:   ld_next = {24'h0, rshift[7:0]};
      2'b10:   ld_next = {16'h0, rshift[15:0]};
      default: ld_next = rshift;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      req_size      <= 2'b00;
      req_off       <= 2'b00;
      req_we        <= 1'b0;
      trap_pend     <= 1'b0;
      bus.busy      <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_be    <= '0;
      bus.mem_wdata <= '0;
      bus.ld_data   <= '0;
      bus.ld_sel    <= 2'b00;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            req_size      <= bus.size;
            req_off       <= off_next;
            req_we        <= bus.we;
            bus.mem_addr  <= {bus.addr[31:2], 2'b00};
            bus.mem_be    <= be_next;
            bus.mem_wdata <= wdata_next;
            bus.busy      <= 1'b1;
            if (trap) begin
              state     <= DONE;
              trap_pend <= 1'b1;
            end else begin
              state       <= ISSUE;
              bus.mem_req <= 1'b1;
              bus.mem_we  <= bus.we;
            end
          end
        end
        ISSUE: begin
          // ack takes priority over a timeout landing on the same edge
          if (bus.mem_ack) begin
            state       <= DONE;
            bus.mem_req <= 1'b0;
            bus.mem_we  <= 1'b0;
            bus.done    <= 1'b1;
            bus.err     <= 1'b0;
            if (!req_we) begin
              bus.ld_data <= ld_next;
              bus.ld_sel  <= req_size;
            end
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            state       <= DONE;
            bus.mem_req <= 1'b0;
            bus.mem_we  <= 1'b0;
            bus.done    <= 1'b1;
            bus.err     <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        DONE: begin
          if (trap_pend) begin
            trap_pend <= 1'b0;
            bus.done  <= 1'b1;
            bus.err   <= 1'b1;
          end else begin
            state    <= IDLE;
            wait_cnt <= '0;
            bus.busy <= 1'b0;
            bus.err  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit against a byte-lane arithmetic model.
module tb_load_store_unit;
  localparam int TIMEOUT = 15;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;
  logic [31:0] m_ld;
  logic [1:0]  m_sel;

  load_store_unit_if bus ();

  load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic check_idle_zero(input string tag);
    check_eq({tag, "_busy"}, 32'(bus.busy), 0);
    check_eq({tag, "_req"}, 32'(bus.mem_req), 0);
    check_eq({tag, "_we"}, 32'(bus.mem_we), 0);
    check_eq({tag, "_done"}, 32'(bus.done), 0);
    check_eq({tag, "_err"}, 32'(bus.err), 0);
    check_eq({tag, "_addr"}, bus.mem_addr, 0);
    check_eq({tag, "_be"}, 32'(bus.mem_be), 0);
    check_eq({tag, "_wdata"}, bus.mem_wdata, 0);
    check_eq({tag, "_ld"}, bus.ld_data, 0);
    check_eq({tag, "_sel"}, 32'(bus.ld_sel), 0);
  endtask

  // One request from IDLE to IDLE; waits = idle ISSUE cycles before ack.
  task automatic run_txn(input logic w, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd,
                         input int waits, input bit no_ack);
    int n, nbytes, off;
    bit trap;
    logic [31:0] e_be, e_wd, mask;
    case (sz)
      2'b01:   begin nbytes = 1; off = int'(a[1:0]); end
      2'b10:   begin nbytes = 2; off = a[1] ? 2 : 0; end
      default: begin nbytes = 4; off = 0; end
    endcase
    e_be = ((32'd1 << nbytes) - 1) << off;
    e_wd = (nbytes == 1) ? wd[7:0] * 32'h01010101 :
           (nbytes == 2) ? wd[15:0] * 32'h00010001 : wd;
    mask = (nbytes == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * nbytes)) - 1;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = (nbytes == 2 && a[0]) || (nbytes == 4 && a[1:0] != 2'b00);
`else
    trap = 1'b0;
`endif
    @(negedge clk);
    bus.start = 1'b1; bus.we = w; bus.size = sz; bus.addr = a; bus.wdata = wd;
    @(negedge clk);
    bus.start = 1'b0; bus.addr = $urandom; bus.wdata = $urandom; bus.we = ~w;
    check_eq("busy", 32'(bus.busy), 1);
    if (trap) begin
      check_eq("trap_noreq", 32'(bus.mem_req), 0);
      @(negedge clk);
      check_eq("trap_done", 32'(bus.done), 1);
      check_eq("trap_err", 32'(bus.err), 1);
      check_eq("trap_noreq2", 32'(bus.mem_req), 0);
    end else begin
      check_eq("req", 32'(bus.mem_req), 1);
      check_eq("mem_addr", bus.mem_addr, {a[31:2], 2'b00});
      check_eq("mem_be", 32'(bus.mem_be), e_be);
      check_eq("mem_we", 32'(bus.mem_we), 32'(w));
      if (w) check_eq("mem_wdata", bus.mem_wdata, e_wd);
      if (no_ack) begin
        n = 0;
        while (bus.mem_req === 1'b1 && n < 100) begin
          n++;
          @(negedge clk);
        end
        check_eq("req_cycles", n, TIMEOUT);
        check_eq("to_done", 32'(bus.done), 1);
        check_eq("to_err", 32'(bus.err), 1);
      end else begin
        repeat (waits) @(negedge clk);
        check_eq("req_held", 32'(bus.mem_req), 1);
        check_eq("be_held", 32'(bus.mem_be), e_be);
        bus.mem_ack = 1'b1; bus.mem_rdata = rd;
        @(negedge clk);
        bus.mem_ack = 1'b0; bus.mem_rdata = $urandom;
        check_eq("done", 32'(bus.done), 1);
        check_eq("err", 32'(bus.err), 0);
        check_eq("req_drop", 32'(bus.mem_req), 0);
        if (!w) begin
          m_ld  = (rd >> (8 * off)) & mask;
          m_sel = sz;
        end
      end
    end
    check_eq("ld_data", bus.ld_data, m_ld);
    check_eq("ld_sel", 32'(bus.ld_sel), 32'(m_sel));
    @(negedge clk);
    check_eq("done_once", 32'(bus.done), 0);
    check_eq("idle_busy", 32'(bus.busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_pass = 0; m_ld = '0; m_sel = 2'b00;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.we = 1'b0; bus.size = 2'b00; bus.addr = '0; bus.wdata = '0;
    bus.mem_rdata = '0; bus.mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_zero("reset");
    rst_n = 1'b1;

    // Stray ack while idle must not complete anything.
    @(negedge clk); bus.mem_ack = 1'b1;
    @(negedge clk); bus.mem_ack = 1'b0;
    check_eq("idle_ack_done", 32'(bus.done), 0);
    check_eq("idle_ack_busy", 32'(bus.busy), 0);

    run_txn(1'b0, 2'b01, 32'h0000_0103, 32'h0, 32'hA1B2_C3D4, 0, 1'b0);
    run_txn(1'b1, 2'b10, 32'h0000_0202, 32'h0000_BEEF, 32'h0, 3, 1'b0);
    run_txn(1'b0, 2'b00, 32'h0000_0500, 32'h0, 32'h0, 0, 1'b1);
    run_txn(1'b0, 2'b10, 32'h0000_0301, 32'h0, 32'h1234_5678, 1, 1'b0);
    run_txn(1'b0, 2'b00, 32'h0000_0600, 32'h0, 32'hDEAD_BEEF, TIMEOUT - 1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_txn(1'($urandom), 2'($urandom), $urandom, $urandom, $urandom,
              int'($urandom_range(0, 4)), ($urandom_range(0, 7) == 0));
    end

    // Second start during ISSUE is ignored, then reset aborts the access.
    @(negedge clk);
    bus.start = 1'b1; bus.we = 1'b0; bus.size = 2'b00; bus.addr = 32'h0000_0400;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.we = 1'b1; bus.addr = 32'h0000_0800;
    @(negedge clk); bus.start = 1'b0;
    check_eq("ign_addr", bus.mem_addr, 32'h0000_0400);
    check_eq("ign_we", 32'(bus.mem_we), 0);
    check_eq("ign_req", 32'(bus.mem_req), 1);
    rst_n = 1'b0;
    #1;
    check_idle_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    m_ld = '0; m_sel = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("post_rst_done", 32'(bus.done), 0);
      check_eq("post_rst_busy", 32'(bus.busy), 0);
    end
    run_txn(1'b0, 2'b00, 32'h0000_0A00, 32'h0, 32'h0BAD_F00D, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
